alu_share_arbiter: RTL

Two-port arbiter sharing one `ALU` instance between two requesters, e.g. the execute stage (port 0) and an address-generation/branch helper (port 1). Each port has a valid/ready request channel and a valid/ready response channel. The block accepts at most one operation per cycle and holds its registered result until the owning port takes it. Arbitration is round-robin by default.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu.sv | 47 ++++
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU ctrl codes, op limit and arbiter port-index type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 5'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 5'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 5'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 5'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 5'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 5'd9;

    localparam int ALU_OP_MAX = 9;

    typedef logic [0:0] port_idx_t;

    function automatic logic [1:0] port_onehot(input port_idx_t p);
        return p[0] ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational integer ALU; zero flag qualifies subtract only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [ALU_CTRL_W-1:0] ctrl,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic [W-1:0]          result,
    output logic                  zero
);

    localparam int SHW = $clog2(W);

    logic [SHW-1:0] w_shamt;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: result = a << w_shamt;
            ALU_SRL: result = a >> w_shamt;
            ALU_SRA: result = $signed(a) >>> w_shamt;
            default: result = '0;
        endcase
    end

    assign zero = (ctrl == ALU_SUB) && (result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Two-port valid/ready arbiter sharing one ALU with a one-deep
//               result register. Define ALU_SHARE_ARB_FIXED_PRI_EN for fixed
//               port-0 priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int OP_MAX = ALU_OP_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [ALU_CTRL_W-1:0] req_ctrl0,
    input  logic [ALU_CTRL_W-1:0] req_ctrl1,
    input  logic [W-1:0]          req_a0,
    input  logic [W-1:0]          req_b0,
    input  logic [W-1:0]          req_a1,
    input  logic [W-1:0]          req_b1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [W-1:0]          rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err
);

    localparam logic [0:0]            S_EMPTY   = 1'b0;
    localparam logic [0:0]            S_FULL    = 1'b1;
    localparam logic [ALU_CTRL_W-1:0] c_op_max  = ALU_CTRL_W'(OP_MAX);

    logic [0:0]            r_state;
    port_idx_t             r_owner;
    logic [W-1:0]          r_result;
    logic                  r_zero;
    logic                  r_err;

    logic                  w_out_valid;
    logic                  w_drain;
    logic                  w_can_accept;
    logic                  w_tie;
    port_idx_t             w_tie_winner;
    port_idx_t             w_winner;
    logic                  w_accept;
    logic [ALU_CTRL_W-1:0] w_ctrl;
    logic [W-1:0]          w_a;
    logic [W-1:0]          w_b;
    logic [W-1:0]          w_alu_result;
    logic                  w_alu_zero;
    logic                  w_illegal;

    assign w_out_valid  = (r_state == S_FULL);
    assign w_drain      = w_out_valid && rsp_ready[r_owner];
    // Gating with rst_n keeps req_ready low for the whole reset cycle.
    assign w_can_accept = rst_n && (!w_out_valid || w_drain);
    assign w_tie        = &req_valid;

`ifdef ALU_SHARE_ARB_FIXED_PRI_EN
    assign w_tie_winner = 1'b0;
`else
    port_idx_t r_last_grant;

    assign w_tie_winner = ~r_last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
        end
    end
`endif

    assign w_winner  = w_tie ? w_tie_winner : port_idx_t'(req_valid[1]);
    assign req_ready = w_can_accept ? (w_tie ? port_onehot(w_winner) : req_valid) : 2'b00;
    assign w_accept  = |req_ready;

    assign w_ctrl = w_winner[0] ? req_ctrl1 : req_ctrl0;
    assign w_a    = w_winner[0] ? req_a1    : req_a0;
    assign w_b    = w_winner[0] ? req_b1    : req_b0;

    assign w_illegal = (w_ctrl > c_op_max);

    alu #(
        .W (W)
    ) u_alu (
        .ctrl   (w_ctrl),
        .a      (w_a),
        .b      (w_b),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    // Accept has priority over drain so accept-and-drain stays FULL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_state  <= S_FULL;
            r_owner  <= w_winner;
            r_result <= w_illegal ? '0 : w_alu_result;
            r_zero   <= !w_illegal && w_alu_zero;
            r_err    <= w_illegal;
        end else if (w_drain) begin
            r_state  <= S_EMPTY;
        end
    end

    assign rsp_valid  = w_out_valid ? port_onehot(r_owner) : 2'b00;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

`default_nettype wire
